// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch front end: issues word fetches, tracks outstanding reads, buffers
// responses with their PC for decode, and flushes on redirect. FETCH_PERF_CNT_EN adds perf counters.
module fetch_prefetch_unit #(
   parameter int unsigned     XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0,
   parameter int unsigned     FIFO_DEPTH   = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            fetch_en,
   input  logic            redir_valid,
   input  logic [XLEN-1:0] redir_pc,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   output logic            inst_valid,
   output logic [XLEN-1:0] inst_data,
   output logic [XLEN-1:0] inst_pc,
   input  logic            inst_ready
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]     perf_fetched,
   output logic [31:0]     perf_flushed
`endif
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

   typedef enum logic {IDLE, RUN} state_e;

   state_e                          state_q, state_d;
   logic [XLEN-1:0]                 fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0]                 resp_pc_q, resp_pc_d;
   logic [CW-1:0]                   cnt_q, cnt_d;
   logic [CW-1:0]                   out_q, out_d;
   logic [CW-1:0]                   drop_q, drop_d;
   logic [AW-1:0]                   wptr_q, wptr_d;
   logic [AW-1:0]                   rptr_q, rptr_d;
   logic [FIFO_DEPTH-1:0][XLEN-1:0] data_q;
   logic [FIFO_DEPTH-1:0][XLEN-1:0] pc_q;

   logic [XLEN-1:0] redir_tgt;
   logic [CW:0]     inflight;
   logic            gnt_fire, rsp_vld, push, pop, drop_rsp;

   assign redir_tgt = {redir_pc[XLEN-1:2], 2'b00};
   assign inflight  = {1'b0, cnt_q} + {1'b0, out_q};

   // Responses arriving with nothing outstanding are protocol violations and ignored.
   assign rsp_vld  = imem_rvalid & (out_q != '0);
   assign drop_rsp = rsp_vld & (drop_q != '0);
   assign push     = rsp_vld & (drop_q == '0);
   assign pop      = inst_valid & inst_ready;
   assign gnt_fire = imem_req & imem_gnt;

   assign imem_addr  = fetch_pc_q;
   assign inst_valid = (cnt_q != '0);
   assign inst_data  = data_q[rptr_q];
   assign inst_pc    = pc_q[rptr_q];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      imem_req = 1'b0;
      case (state_q)
         IDLE: if (fetch_en) state_d = RUN;
         RUN: begin
            imem_req = !redir_valid && (inflight < DEPTH_C);
            if (!fetch_en) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      out_d      = out_q + CW'(gnt_fire) - CW'(rsp_vld);
      fetch_pc_d = fetch_pc_q;
      resp_pc_d  = resp_pc_q;
      cnt_d      = cnt_q;
      drop_d     = drop_q;
      wptr_d     = wptr_q;
      rptr_d     = rptr_q;
      if (redir_valid) begin
         // Everything still in flight after this edge belongs to the old path.
         fetch_pc_d = redir_tgt;
         resp_pc_d  = redir_tgt;
         cnt_d      = '0;
         wptr_d     = '0;
         rptr_d     = '0;
         drop_d     = out_d;
      end else begin
         if (gnt_fire) fetch_pc_d = fetch_pc_q + XLEN'(4);
         if (push)     resp_pc_d  = resp_pc_q + XLEN'(4);
         drop_d = drop_q - CW'(drop_rsp);
         wptr_d = wptr_q + AW'(push);
         rptr_d = rptr_q + AW'(pop);
         cnt_d  = cnt_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_pc_q <= RESET_VECTOR;
         resp_pc_q  <= RESET_VECTOR;
         cnt_q      <= '0;
         out_q      <= '0;
         drop_q     <= '0;
         wptr_q     <= '0;
         rptr_q     <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         resp_pc_q  <= resp_pc_d;
         cnt_q      <= cnt_d;
         out_q      <= out_d;
         drop_q     <= drop_d;
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_q <= '0;
         pc_q   <= {FIFO_DEPTH{RESET_VECTOR}};
      end else if (push && !redir_valid) begin
         data_q[wptr_q] <= imem_rdata;
         pc_q[wptr_q]   <= resp_pc_q;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_fetched_q, perf_flushed_q;
   logic [CW:0] flush_amt;
   logic [32:0] flushed_sum;

   // Flushed entries include a push landing in the redirect cycle; a same-cycle pop was consumed.
   always_comb begin
      flush_amt = (CW+1)'(drop_rsp);
      if (redir_valid)
         flush_amt = flush_amt + {1'b0, cnt_q} + (CW+1)'(push) - (CW+1)'(pop);
      flushed_sum = {1'b0, perf_flushed_q} + 33'(flush_amt);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_fetched_q <= '0;
         perf_flushed_q <= '0;
      end else begin
         if (pop && (perf_fetched_q != '1)) perf_fetched_q <= perf_fetched_q + 32'd1;
         perf_flushed_q <= flushed_sum[32] ? '1 : flushed_sum[31:0];
      end
   end

   assign perf_fetched = perf_fetched_q;
   assign perf_flushed = perf_flushed_q;
`endif

endmodule
